// File: rtl/gamepad_reader.sv
// Host-side reader for an NES-style serial gamepad: latch/clock/data, 8 active-low bits.
// Optional two-read agreement filter on the button outputs: define GAMEPAD_FILTER_EN.
module gamepad_reader #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_poll,
    input  logic i_pad_data,
    output logic o_pad_latch,
    output logic o_pad_clk,
    output logic o_up,
    output logic o_down,
    output logic o_left,
    output logic o_right,
    output logic o_pause,
    output logic o_restart,
    output logic o_a,
    output logic o_b,
    output logic o_present,
    output logic o_valid,
    output logic o_busy
);

    // state    | meaning
    // S_IDLE   | waiting for i_poll
    // S_LATCH  | latch strobe high for 2*CLK_DIV cycles
    // S_SETTLE | latch low, bit0 sampled on last cycle
    // S_CLK_HI | pad clock high, pad shifts next bit out
    // S_CLK_LO | pad clock low, bit sampled on last cycle
    // S_DONE   | outputs updated, o_valid pulse
    typedef enum logic [2:0] {
        S_IDLE, S_LATCH, S_SETTLE, S_CLK_HI, S_CLK_LO, S_DONE
    } state_t;

    state_t     state, state_nx;
    logic [7:0] phase, phase_nx;
    logic [2:0] bit_cnt, bit_cnt_nx;
    logic       phase_tc;
    logic       sample, last_sample;
    logic       sync1, sync2;
    logic [7:0] shreg;
    logic [7:0] raw_word;
    logic [7:0] btn_clean;
    logic [7:0] btn_q;
    logic       present_q;
    logic       absent;

    assign phase_tc = (phase == 8'(CLK_DIV - 1));

    always_comb begin
        state_nx    = state;
        phase_nx    = phase_tc ? 8'd0 : phase + 8'd1;
        bit_cnt_nx  = bit_cnt;
        sample      = 1'b0;
        last_sample = 1'b0;
        case (state)
            S_IDLE: begin
                phase_nx   = 8'd0;
                bit_cnt_nx = 3'd0;
                if (i_poll) state_nx = S_LATCH;
            end
            S_LATCH: begin
                // two phase periods, bit_cnt marks the second one
                if (phase_tc) begin
                    if (bit_cnt == 3'd1) begin
                        bit_cnt_nx = 3'd0;
                        state_nx   = S_SETTLE;
                    end else begin
                        bit_cnt_nx = 3'd1;
                    end
                end
            end
            S_SETTLE: begin
                if (phase_tc) begin
                    sample     = 1'b1;
                    bit_cnt_nx = 3'd1;
                    state_nx   = S_CLK_HI;
                end
            end
            S_CLK_HI: begin
                if (phase_tc) state_nx = S_CLK_LO;
            end
            S_CLK_LO: begin
                if (phase_tc) begin
                    sample = 1'b1;
                    if (bit_cnt == 3'd7) begin
                        last_sample = 1'b1;
                        state_nx    = S_DONE;
                    end else begin
                        bit_cnt_nx = bit_cnt + 3'd1;
                        state_nx   = S_CLK_HI;
                    end
                end
            end
            S_DONE: begin
                phase_nx = 8'd0;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            phase   <= 8'd0;
            bit_cnt <= 3'd0;
        end else begin
            state   <= state_nx;
            phase   <= phase_nx;
            bit_cnt <= bit_cnt_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= i_pad_data;
            sync2 <= sync1;
        end
    end

    // incoming bit enters at the top; after 8 samples bit0 sits at position 0
    assign raw_word = {~sync2, shreg[7:1]};
    assign absent   = &raw_word;

    always_comb begin
        btn_clean = raw_word;
        if (raw_word[4] && raw_word[5]) btn_clean[5:4] = 2'b00;
        if (raw_word[6] && raw_word[7]) btn_clean[7:6] = 2'b00;
        if (absent) btn_clean = 8'd0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) shreg <= 8'd0;
        else if (sample) shreg <= raw_word;
    end

`ifdef GAMEPAD_FILTER_EN
    logic [7:0] prev_raw;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_raw  <= 8'd0;
            btn_q     <= 8'd0;
            present_q <= 1'b0;
        end else if (last_sample) begin
            prev_raw  <= raw_word;
            present_q <= ~absent;
            if (absent || (raw_word == prev_raw)) btn_q <= btn_clean;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_q     <= 8'd0;
            present_q <= 1'b0;
        end else if (last_sample) begin
            btn_q     <= btn_clean;
            present_q <= ~absent;
        end
    end
`endif

    assign o_pad_latch = (state == S_LATCH);
    assign o_pad_clk   = (state == S_CLK_HI);
    assign o_valid     = (state == S_DONE);
    assign o_busy      = (state != S_IDLE);
    assign o_present   = present_q;
    assign o_a         = btn_q[0];
    assign o_b         = btn_q[1];
    assign o_restart   = btn_q[2];
    assign o_pause     = btn_q[3];
    assign o_up        = btn_q[4];
    assign o_down      = btn_q[5];
    assign o_left      = btn_q[6];
    assign o_right     = btn_q[7];

endmodule

// File: tb/tb_gamepad_reader.sv
// Directed bench for gamepad_reader with a behavioural NES pad model (CLK_DIV = 4).
// Build with GAMEPAD_FILTER_EN defined to exercise the agreement filter.
module tb_gamepad_reader;

    logic clk = 1'b0;
    logic rst_n;
    logic i_poll;
    logic i_pad_data;
    logic o_pad_latch, o_pad_clk;
    logic o_up, o_down, o_left, o_right, o_pause, o_restart, o_a, o_b;
    logic o_present, o_valid, o_busy;

    always #5 clk = ~clk;

    gamepad_reader #(.CLK_DIV(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_poll     (i_poll),
        .i_pad_data (i_pad_data),
        .o_pad_latch(o_pad_latch),
        .o_pad_clk  (o_pad_clk),
        .o_up       (o_up),
        .o_down     (o_down),
        .o_left     (o_left),
        .o_right    (o_right),
        .o_pause    (o_pause),
        .o_restart  (o_restart),
        .o_a        (o_a),
        .o_b        (o_b),
        .o_present  (o_present),
        .o_valid    (o_valid),
        .o_busy     (o_busy)
    );

`ifdef GAMEPAD_FILTER_EN
    localparam bit PRIME = 1'b1;
`else
    localparam bit PRIME = 1'b0;
`endif

    // pad model: parallel load while latched, shift on pad clock rise
    logic [7:0] pad_word;
    logic       pad_conn;
    logic [7:0] pad_sr = 8'd0;
    logic       pad_clk_q = 1'b0;

    always @(posedge clk) begin
        pad_clk_q <= o_pad_clk;
        if (o_pad_latch) pad_sr <= pad_word;
        else if (o_pad_clk && !pad_clk_q) pad_sr <= {1'b0, pad_sr[7:1]};
    end

    assign i_pad_data = pad_conn ? ~pad_sr[0] : 1'b0;

    wire [7:0] btn = {o_right, o_left, o_down, o_up, o_pause, o_restart, o_b, o_a};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    int latch_cnt, latch_first, latch_last;
    int rise_cnt, rise_first, rise_last;
    int valid_cnt, valid_cyc, busy_last, lines_after_rst;
    logic [7:0] btn_at_valid;
    logic       pres_at_valid;

    // one read; cycle T is the one with i_poll high, record covers T+1..T+80
    task automatic do_read(input logic [7:0] w, input logic conn, input int extra_poll,
                           input int rst_at, input bit prime);
        int  npass;
        logic prev_clk;
        bit  last;
        npass    = prime ? 2 : 1;
        pad_word = w;
        pad_conn = conn;
        for (int p = 0; p < npass; p++) begin
            latch_cnt = 0; latch_first = -1; latch_last = -1;
            rise_cnt = 0; rise_first = -1; rise_last = -1;
            valid_cnt = 0; valid_cyc = -1; busy_last = -1; lines_after_rst = -1;
            btn_at_valid = 8'd0; pres_at_valid = 1'b0;
            prev_clk = 1'b0;
            last = (p == npass - 1);
            @(negedge clk);
            i_poll = 1'b1;
            for (int n = 1; n <= 80; n++) begin
                @(negedge clk);
                if (o_pad_latch) begin
                    latch_cnt++;
                    if (latch_first < 0) latch_first = n;
                    latch_last = n;
                end
                if (o_pad_clk && !prev_clk) begin
                    rise_cnt++;
                    if (rise_first < 0) rise_first = n;
                    rise_last = n;
                end
                prev_clk = o_pad_clk;
                if (o_valid) begin
                    valid_cnt++;
                    valid_cyc = n;
                    btn_at_valid = btn;
                    pres_at_valid = o_present;
                end
                if (o_busy) busy_last = n;
                if (last && rst_at > 0 && n == rst_at + 1)
                    lines_after_rst = int'({o_pad_latch, o_pad_clk, o_busy});
                i_poll = last && (n == extra_poll);
                rst_n  = !(last && (n == rst_at));
            end
            i_poll = 1'b0;
            rst_n  = 1'b1;
        end
    endtask

    initial begin
        int nz;
        rst_n = 1'b0; i_poll = 1'b0; pad_word = 8'd0; pad_conn = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("reset_buttons", int'(btn), 0);
        check("reset_ctrl", int'({o_present, o_valid, o_busy, o_pad_latch, o_pad_clk}), 0);

        nz = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if ({btn, o_present, o_valid, o_busy, o_pad_latch, o_pad_clk} != '0) nz++;
        end
        check("idle_quiet", nz, 0);

        // Up only, with a dropped poll on the DONE cycle
        do_read(8'h10, 1'b1, 69, 0, PRIME);
        check("latch_cnt", latch_cnt, 8);
        check("latch_first", latch_first, 1);
        check("latch_last", latch_last, 8);
        check("rise_cnt", rise_cnt, 7);
        check("rise_first", rise_first, 13);
        check("rise_last", rise_last, 61);
        check("valid_cyc", valid_cyc, 69);
        check("valid_cnt", valid_cnt, 1);
        check("busy_last", busy_last, 69);
        check("up_btn", int'(btn_at_valid), 'h10);
        check("up_present", int'(pres_at_valid), 1);

        do_read(8'h00, 1'b0, 0, 0, PRIME);
        check("absent_btn", int'(btn), 0);
        check("absent_present", int'(o_present), 0);
        check("absent_valid", valid_cnt, 1);

        do_read(8'h48, 1'b1, 0, 0, PRIME);
        check("start_left_btn", int'(btn), 'h48);
        check("start_left_present", int'(o_present), 1);

        do_read(8'h00, 1'b1, 0, 0, PRIME);
        check("none_btn", int'(btn), 0);
        check("none_present", int'(o_present), 1);

        do_read(8'hC1, 1'b1, 0, 0, PRIME);
        check("left_right_a", int'(btn), 'h01);

        // Up+Down+Right with a mid-read poll
        do_read(8'hB0, 1'b1, 20, 0, PRIME);
        check("up_down_right", int'(btn), 'h80);
        check("midpoll_valid_cnt", valid_cnt, 1);
        check("midpoll_valid_cyc", valid_cyc, 69);
        check("midpoll_latch_cnt", latch_cnt, 8);

        do_read(8'h22, 1'b1, 0, 30, PRIME);
        check("rst_lines", lines_after_rst, 0);
        check("rst_valid", valid_cnt, 0);
        check("rst_busy_last", busy_last, 30);
        check("rst_btn", int'(btn), 0);
        check("rst_present", int'(o_present), 0);

        do_read(8'h01, 1'b1, 0, 0, PRIME);
        check("after_rst_btn", int'(btn), 'h01);
        check("after_rst_valid", valid_cnt, 1);

`ifdef GAMEPAD_FILTER_EN
        do_read(8'h01, 1'b1, 0, 0, 1'b0);
        do_read(8'h01, 1'b1, 0, 0, 1'b0);
        check("filt_aa_btn", int'(btn), 'h01);
        do_read(8'h02, 1'b1, 0, 0, 1'b0);
        check("filt_ab_btn", int'(btn), 'h01);
        check("filt_ab_valid", valid_cnt, 1);
        check("filt_ab_present", int'(o_present), 1);
        do_read(8'h02, 1'b1, 0, 0, 1'b0);
        check("filt_bb_btn", int'(btn), 'h02);
        check("filt_bb_valid", valid_cnt, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gamepad_reader.md
Name: gamepad_reader

Overview:
- Host-side reader for an NES-style serial gamepad (latch / clock / data, 8 bits, active-low data).
- Drives the latch and clock lines and shifts in the 8 button bits.
- Presents the result as level buttons that feed the game core's up/down/left/right/pause/restart inputs.
- Sits between the board pins and the game top; one read per i_poll pulse (normally the frame vsync edge).

Parameters:
- CLK_DIV, 4, clk cycles per pad-clock half period; legal range 4..255. The 2-flop data sync plus settle must fit inside one half period.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- i_poll  in  1  single-cycle read request; ignored unless the FSM is in IDLE
- i_pad_data  in  1  serial data from pad; active low (0 = pressed); board pull-down
- o_pad_latch  out  1  latch strobe to pad
- o_pad_clk  out  1  shift clock to pad
- o_up, o_down, o_left, o_right  out  1 each  direction buttons, 1 = pressed
- o_pause  out  1  Start button
- o_restart  out  1  Select button
- o_a, o_b  out  1 each  A/B buttons
- o_present  out  1  last read came from a connected pad
- o_valid  out  1  one-cycle pulse when a read completes and outputs update
- o_busy  out  1  FSM not in IDLE

Behaviour:
- Reset is decided as: rst_n is synchronous, active-low; clock is clk.
- Reset values:
  - All button outputs, o_present, o_valid, o_busy, o_pad_latch and o_pad_clk = 0.
  - Shift register = 0; FSM = IDLE.
  - Sync flops reset to 1 (the "not pressed" level).
- Reset mid-read: abort immediately; lines low next cycle; no o_valid.
- i_pad_data passes through 2 flops before any use. All sampling uses the synced value, inverted, so stored bits are 1 = pressed.
- Bit order on the wire: bit0 A, bit1 B, bit2 Select, bit3 Start, bit4 Up, bit5 Down, bit6 Left, bit7 Right.
- Timing, with D = CLK_DIV and i_poll sampled high in IDLE at cycle T:
  - LATCH: o_pad_latch = 1 for cycles T+1 .. T+2D.
  - SETTLE: latch = 0 for D cycles; bit0 sampled at cycle T+3D.
  - For k = 1..7:
    - CLK_HI: o_pad_clk = 1 for D cycles.
    - CLK_LO: o_pad_clk = 0 for D cycles.
    - bit k sampled on the last CLK_LO cycle (T+3D+2kD).
  - DONE: cycle T+17D+1. All button outputs and o_present update and o_valid = 1, all in that same cycle. FSM returns to IDLE next cycle.
- o_busy = 1 from T+1 through T+17D+1 inclusive.
- A 3-bit bit counter and an 8-bit phase counter (counts 0..D-1) drive the FSM. No other timing source.
- i_poll asserted while busy: dropped, not queued.
- i_poll asserted on the DONE cycle: dropped. The next read needs i_poll while in IDLE.
- Absent-pad detection:
  - If all 8 sampled bits are pressed (the pull-down reads 0 throughout), the read is absent.
  - Absent result: o_present = 0 and all button outputs forced to 0; o_valid still pulses.
  - Otherwise o_present = 1 and outputs = sampled bits.
- Contradictory directions (Up and Down both pressed, or Left and Right both pressed): both bits of that pair are forced to 0. The other pair is unaffected.
- Between reads, outputs hold their last values.

Optional Feature:
- Macro: GAMEPAD_FILTER_EN.
- Defined: two-read agreement filter.
  - The new 8-bit word updates the button outputs only if it equals the previous raw word.
  - The previous raw word is stored every read; reset value 0.
  - o_present and o_valid behave the same with or without the filter.
  - o_valid still pulses on every completed read.
- Undefined: each read updates the outputs directly. The filter register is not instantiated.

Test Plan:
- Reset then idle, CLK_DIV=4, no i_poll for 200 cycles -> latch = 0, pad clock = 0, o_busy = 0, every output 0 throughout.
- Timing check: i_poll at T, pad model presents word 8'b0001_0000 (Up only) -> latch high at T+1..T+8; 7 pad-clock rising edges at T+13, T+21, ..., T+61; o_valid at T+69 with o_up = 1, o_present = 1, all other buttons 0.
- Pad held at 0 (disconnected) -> after o_valid: o_present = 0, all buttons 0. Then pad sends Start + Left (bits 3 and 6) -> o_pause = 1, o_left = 1, o_present = 1.
- Up + Down + Right pressed -> o_up = 0, o_down = 0, o_right = 1. Then i_poll pulsed at T+20 mid-read -> ignored, exactly one o_valid.
- rst_n low at T+30 mid-read -> lines low at T+31, no o_valid; outputs 0. A fresh read afterwards completes normally.
- GAMEPAD_FILTER_EN defined: reads A, B, B -> after read 2 o_a = 1, o_b = 0; after read 3 o_a = 0, o_b = 1. o_valid pulses all three times.
